// File: rtl/nlp16a_alu_pkg.sv
// Shared definitions for the nlp-16a internal ALU sequencer: op codes, FSM states, strobe patterns.
package nlp16a_alu_pkg;

  localparam int unsigned OP_W  = 2;
  localparam int unsigned CNT_W = 4;

  localparam logic [OP_W-1:0] OP_MOV  = 2'b00;
  localparam logic [OP_W-1:0] OP_INC  = 2'b01;
  localparam logic [OP_W-1:0] OP_DEC  = 2'b10;
  localparam logic [OP_W-1:0] OP_ADDR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_EXEC  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Active-low control strobes to the ALU control decoders (MSB first).
  typedef struct packed {
    logic mov_n;
    logic addr_n;
    logic incdec_n;
    logic dec_n;
  } strobe_t;

  localparam strobe_t STB_IDLE = '{mov_n: 1'b1, addr_n: 1'b1, incdec_n: 1'b1, dec_n: 1'b1};
  localparam strobe_t STB_MOV  = '{mov_n: 1'b0, addr_n: 1'b1, incdec_n: 1'b1, dec_n: 1'b1};
  localparam strobe_t STB_INC  = '{mov_n: 1'b0, addr_n: 1'b1, incdec_n: 1'b0, dec_n: 1'b1};
  localparam strobe_t STB_DEC  = '{mov_n: 1'b0, addr_n: 1'b1, incdec_n: 1'b0, dec_n: 1'b0};
  localparam strobe_t STB_ADDR = '{mov_n: 1'b1, addr_n: 1'b0, incdec_n: 1'b1, dec_n: 1'b1};

  // Map an op code to its strobe pattern.
  function automatic strobe_t op_to_strobe(input logic [OP_W-1:0] op);
    strobe_t stb;
    case (op)
      OP_MOV:  stb = STB_MOV;
      OP_INC:  stb = STB_INC;
      OP_DEC:  stb = STB_DEC;
      default: stb = STB_ADDR;
    endcase
    return stb;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above the pointer, wrapping.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDXW = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic            valid_o_c,
  output logic [IDXW-1:0] idx_o_c
);

  // Scan from the farthest offset down so the nearest request to the pointer wins.
  always_comb begin
    int unsigned pos;
    valid_o_c = 1'b0;
    idx_o_c   = '0;
    pos       = 0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      pos = (int'(ptr_i) + i) % NREQ;
      if (req_i[pos]) begin
        valid_o_c = 1'b1;
        idx_o_c   = IDXW'(pos);
      end
    end
  end

endmodule

// File: rtl/alu_internal_seq.sv
// Round-robin sequencer for internal ALU ops (MOV/INC/DEC/ADDR) of the nlp-16a core.
module alu_internal_seq
  import nlp16a_alu_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned EXEC_CYCLES = 2,
  parameter int unsigned IDXW        = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_i,
  input  logic [2*NREQ-1:0] op_i,
  input  logic              hold_i,
  output logic [NREQ-1:0]   ack_o,
  output logic [IDXW-1:0]   grant_idx_o,
  output logic              busy_o,
  output logic              wr_en_o,
  output logic              internal_mov_n,
  output logic              address_mode_n,
  output logic              internal_inc_dec_n,
  output logic              internal_dec_n
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);
  localparam logic [IDXW-1:0]  IDX_LAST = IDXW'(NREQ - 1);

  state_t           r_state, w_state_nxt;
  logic [IDXW-1:0]  r_grant, w_grant_nxt;
  logic [IDXW-1:0]  r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  strobe_t          r_stb, w_stb_nxt;
  logic [NREQ-1:0]  r_ack, w_ack_nxt;
  logic             r_wr, w_wr_nxt;
  logic             r_busy, w_busy_nxt;

  logic             w_arb_valid;
  logic [IDXW-1:0]  w_arb_idx;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_rr_arbiter (
    .req_i     (req_i),
    .ptr_i     (r_ptr),
    .valid_o_c (w_arb_valid),
    .idx_o_c   (w_arb_idx)
  );

  // State and registered-output update; reset drops strobes immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_stb   <= STB_IDLE;
      r_ack   <= '0;
      r_wr    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_stb   <= w_stb_nxt;
      r_ack   <= w_ack_nxt;
      r_wr    <= w_wr_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Next state plus next value of every output register, so outputs align with the state they describe.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_stb_nxt   = r_stb;
    w_ack_nxt   = '0;
    w_wr_nxt    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (!hold_i && w_arb_valid) begin
          w_state_nxt = ST_SETUP;
          w_grant_nxt = w_arb_idx;
          w_stb_nxt   = op_to_strobe(op_i[{w_arb_idx, 1'b0} +: OP_W]);
        end
      end
      ST_SETUP: begin
        w_state_nxt = ST_EXEC;
        w_cnt_nxt   = CNT_LOAD;
      end
      ST_EXEC: begin
        if (r_cnt == '0) begin
          w_state_nxt        = ST_DONE;
          w_ack_nxt[r_grant] = 1'b1;
          w_wr_nxt           = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_stb_nxt   = STB_IDLE;
        w_ptr_nxt   = (r_grant == IDX_LAST) ? '0 : r_grant + IDXW'(1);
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_stb_nxt   = STB_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  assign ack_o              = r_ack;
  assign grant_idx_o        = r_grant;
  assign busy_o             = r_busy;
  assign wr_en_o            = r_wr;
  assign internal_mov_n     = r_stb.mov_n;
  assign address_mode_n     = r_stb.addr_n;
  assign internal_inc_dec_n = r_stb.incdec_n;
  assign internal_dec_n     = r_stb.dec_n;

endmodule

// File: tb/tb_alu_internal_seq.sv
// Bench for alu_internal_seq: directed scenarios plus random traffic against a transaction-timeline model.
module tb_alu_internal_seq;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned EXEC   = 2;
  localparam int unsigned IDXW   = 2;
  localparam int          LAST_K = EXEC + 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_i;
  logic [2*NREQ-1:0] op_i;
  logic              hold_i;
  logic [NREQ-1:0]   ack_o;
  logic [IDXW-1:0]   grant_idx_o;
  logic              busy_o;
  logic              wr_en_o;
  logic              internal_mov_n;
  logic              address_mode_n;
  logic              internal_inc_dec_n;
  logic              internal_dec_n;

  alu_internal_seq #(
    .NREQ        (NREQ),
    .EXEC_CYCLES (EXEC),
    .IDXW        (IDXW)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .req_i              (req_i),
    .op_i               (op_i),
    .hold_i             (hold_i),
    .ack_o              (ack_o),
    .grant_idx_o        (grant_idx_o),
    .busy_o             (busy_o),
    .wr_en_o            (wr_en_o),
    .internal_mov_n     (internal_mov_n),
    .address_mode_n     (address_mode_n),
    .internal_inc_dec_n (internal_inc_dec_n),
    .internal_dec_n     (internal_dec_n)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Model: m_k = cycles since the grant edge (0 = no op in flight).
  int         m_k   = 0;
  int         m_g   = 0;
  int         m_ptr = 0;
  logic [1:0] m_op  = 2'b00;

  logic [3:0]      stb;
  logic [NREQ-1:0] got_ack;
  int              order [5] = '{0, 1, 2, 3, 0};

  assign stb = {internal_mov_n, address_mode_n, internal_inc_dec_n, internal_dec_n};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] pat(input logic [1:0] op);
    case (op)
      2'b00:   return 4'b0111;
      2'b01:   return 4'b0101;
      2'b10:   return 4'b0100;
      default: return 4'b1011;
    endcase
  endfunction

  task automatic model_reset();
    m_k   = 0;
    m_g   = 0;
    m_ptr = 0;
  endtask

  // Advance the model by one clock edge using the inputs held across that edge.
  task automatic model_tick();
    if (!rst_n) begin
      model_reset();
    end else if (m_k == 0) begin
      if (!hold_i && req_i != '0) begin
        for (int i = 0; i < int'(NREQ); i++) begin
          int j;
          j = (m_ptr + i) % int'(NREQ);
          if (req_i[j]) begin
            m_g  = j;
            m_op = op_i[2*j +: 2];
            m_k  = 1;
            break;
          end
        end
      end
    end else if (m_k == LAST_K) begin
      m_k   = 0;
      m_ptr = (m_g + 1) % int'(NREQ);
    end else begin
      m_k++;
    end
  endtask

  task automatic check_all();
    logic [NREQ-1:0] exp_ack;
    exp_ack = '0;
    if (m_k == LAST_K) exp_ack[m_g] = 1'b1;
    chk("busy", 32'(busy_o), 32'(m_k != 0));
    chk("strobes", 32'(stb), 32'((m_k != 0) ? pat(m_op) : 4'hf));
    chk("grant_idx", 32'(grant_idx_o), 32'(m_g));
    chk("ack", 32'(ack_o), 32'(exp_ack));
    chk("wr_en", 32'(wr_en_o), 32'(m_k == LAST_K));
  endtask

  task automatic step();
    @(posedge clk);
    model_tick();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_ack(output logic [NREQ-1:0] a);
    a = '0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (ack_o != '0) begin
        a = ack_o;
        break;
      end
    end
    chk("ack_seen", 32'(a != '0), 32'd1);
  endtask

  task automatic drain();
    req_i  = '0;
    hold_i = 1'b0;
    repeat (LAST_K + 2) step();
  endtask

  initial begin
    rst_n  = 1'b0;
    req_i  = '0;
    op_i   = '0;
    hold_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_strobes", 32'(stb), 32'h0000_000f);
    chk("rst_ack", 32'(ack_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_gidx", 32'(grant_idx_o), 32'd0);
    chk("rst_wr", 32'(wr_en_o), 32'd0);
    rst_n = 1'b1;

    // Single INC from requester 0.
    req_i = 4'b0001;
    op_i  = 8'b0000_0001;
    step();
    chk("t1_setup_stb", 32'(stb), 32'b0101);
    step();
    step();
    step();
    chk("t1_ack", 32'(ack_o), 32'b0001);
    chk("t1_wr", 32'(wr_en_o), 32'd1);
    req_i = '0;
    step();
    chk("t1_idle_stb", 32'(stb), 32'hf);
    drain();

    // All requesters: round-robin order and per-op strobes.
    do_reset();
    req_i = 4'b1111;
    op_i  = 8'b11_10_01_00;
    begin
      int n;
      n = 0;
      for (int c = 0; c < 5 * (LAST_K + 1) + 2 && n < 5; c++) begin
        step();
        if (ack_o != '0) begin
          chk("t2_order", 32'(ack_o), 32'(1) << order[n]);
          chk("t2_stb", 32'(stb), 32'(pat(2'(order[n]))));
          n++;
        end
      end
      chk("t2_count", 32'(n), 32'd5);
    end
    drain();

    // hold_i blocks new grants only while idle.
    do_reset();
    hold_i = 1'b1;
    req_i  = 4'b0010;
    op_i   = 8'b0000_0100;
    repeat (4) begin
      step();
      chk("t3_hold_busy", 32'(busy_o), 32'd0);
    end
    hold_i = 1'b0;
    step();
    chk("t3_setup_busy", 32'(busy_o), 32'd1);
    chk("t3_setup_gidx", 32'(grant_idx_o), 32'd1);
    step();
    hold_i = 1'b1;
    step();
    step();
    chk("t3_ack", 32'(ack_o), 32'b0010);
    req_i = '0;
    drain();

    // Requester drops req mid-op; op still completes.
    do_reset();
    req_i = 4'b0100;
    op_i  = 8'b00_10_00_00;
    step();
    step();
    req_i = '0;
    step();
    chk("t4_exec_stb", 32'(stb), 32'b0100);
    step();
    chk("t4_ack", 32'(ack_o), 32'b0100);
    chk("t4_done_stb", 32'(stb), 32'b0100);
    step();
    chk("t4_idle_stb", 32'(stb), 32'hf);
    drain();

    // Async reset mid-EXEC kills the op; pointer restarts at 0.
    do_reset();
    req_i = 4'b0001;
    op_i  = 8'b0000_0000;
    step();
    step();
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_stb", 32'(stb), 32'hf);
    chk("t5_rst_ack", 32'(ack_o), 32'd0);
    chk("t5_rst_busy", 32'(busy_o), 32'd0);
    model_reset();
    step();
    step();
    rst_n = 1'b1;
    req_i = 4'b1010;
    wait_ack(got_ack);
    chk("t5_first", 32'(got_ack), 32'b0010);
    req_i = 4'b1000;
    wait_ack(got_ack);
    chk("t5_second", 32'(got_ack), 32'b1000);
    drain();

    // Pointer wraps to 0 after serving requester 3.
    do_reset();
    req_i = 4'b1000;
    wait_ack(got_ack);
    chk("t6_first", 32'(got_ack), 32'b1000);
    req_i = 4'b1001;
    step();
    step();
    chk("t6_gidx", 32'(grant_idx_o), 32'd0);
    wait_ack(got_ack);
    chk("t6_second", 32'(got_ack), 32'b0001);
    req_i = 4'b1000;
    wait_ack(got_ack);
    chk("t6_third", 32'(got_ack), 32'b1000);
    drain();

    // Random traffic: requesters hold until acked, ops change freely, occasional hold and reset.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        step();
        rst_n = 1'b1;
      end
      hold_i = ($urandom_range(0, 7) == 0);
      for (int b = 0; b < int'(NREQ); b++) begin
        if (ack_o[b]) req_i[b] = ($urandom_range(0, 3) == 0);
        else if (!req_i[b]) req_i[b] = ($urandom_range(0, 3) == 0);
      end
      op_i = 8'($urandom);
      step();
    end
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_internal_seq.md
Name: alu_internal_seq

Overview:
Sequencer and arbiter for the internal (non-instruction) ALU operations of the nlp-16a core: MOV, INC, DEC and address calculation. It takes requests from up to NREQ internal requesters (PC increment, SP push/pop, effective-address calc, register move) and grants the shared ALU to one requester at a time, round-robin. For each grant it drives the active-low control strobes consumed by the ALU control decoders (internal_mov_n, address_mode_n, internal_inc_dec_n, internal_dec_n). It holds those strobes for a fixed execute window, then returns a one-cycle ack with a write-enable.

Parameters:
NREQ, 4, number of requesters (2..8)
EXEC_CYCLES, 2, cycles the strobes are held for ALU settle before write-back (1..15)
IDXW, 2, width of grant index, equals clog2(NREQ)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_i  in  NREQ  per-requester request, level, held until ack
op_i  in  2*NREQ  per-requester op, slice k = op of requester k: 00 MOV, 01 INC, 10 DEC, 11 ADDR
hold_i  in  1  normal instruction path owns the ALU; blocks new grants
ack_o  out  NREQ  one-hot one-cycle completion pulse
grant_idx_o  out  IDXW  index of the requester currently owning the ALU (operand mux select)
busy_o  out  1  high in any state other than IDLE
wr_en_o  out  1  one-cycle result write-back strobe, coincident with ack
internal_mov_n  out  1  active-low, to ALU ctrl decoders
address_mode_n  out  1  active-low
internal_inc_dec_n  out  1  active-low
internal_dec_n  out  1  active-low

Behaviour:
- Reset (async, immediate): state IDLE; all four strobes 1; ack_o 0; wr_en_o 0; busy_o 0; grant_idx_o 0; rr pointer 0; exec counter 0.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE, SETUP, EXEC, DONE.
- IDLE: if hold_i=0 and req_i!=0, select the first set req bit at or after the rr pointer, searching upward with wrap. Latch the index and its op, go to SETUP. Otherwise stay in IDLE.
- SETUP (1 cycle): strobes driven from the latched op, exec counter loaded with EXEC_CYCLES-1, go to EXEC.
- Strobe encoding (mov_n, addr_n, incdec_n, dec_n):
  - MOV = 0,1,1,1
  - INC = 0,1,0,1
  - DEC = 0,1,0,0
  - ADDR = 1,0,1,1
  - idle/inactive = 1,1,1,1
- EXEC: strobes held. Counter decrements each cycle. At 0, go to DONE.
- DONE (1 cycle): strobes still held. ack_o[grant] and wr_en_o pulse high. rr pointer becomes grant+1 mod NREQ. Next state IDLE, where strobes return to all 1.
- Latency: req seen in IDLE at cycle n gives SETUP at n+1, EXEC n+2..n+1+EXEC_CYCLES, ack at n+2+EXEC_CYCLES.
  - Back-to-back grants always have at least one IDLE cycle between them.
- hold_i is sampled only in IDLE. Once SETUP is entered, the op commits regardless of hold_i.
- A requester dropping req mid-op does not abort it. The op completes and its ack still pulses. A requester must drop req the cycle after ack or it is re-eligible, subject to rr order.
- Op changes during SETUP/EXEC/DONE are ignored because op is latched in IDLE.
- req bits for index >= NREQ do not exist. op_i slices of non-requesting indices are ignored.
- Reset asserted mid-op: strobes go to 1 immediately, no ack is produced, and the interrupted requester must re-request.
- grant_idx_o updates on the IDLE to SETUP transition and holds through DONE.

Decomposition:
- Shared package nlp16a_alu_pkg:
  - op encoding constants OP_MOV/OP_INC/OP_DEC/OP_ADDR
  - state encoding
  - strobe-pattern constants for each op
- One sub-module, rr_arbiter: combinational round-robin pick. Inputs are req vector and pointer; outputs are valid and index. It is reusable for bus arbitration elsewhere.

Test Plan:
1. Reset, then req_i=0001, op[0]=01, EXEC_CYCLES=2 -> strobes become 0,1,0,1 one cycle after req; ack_o=0001 and wr_en_o=1 exactly 4 cycles after req; strobes return to 1111 the next cycle.
2. req_i=1111 held with ops MOV, INC, DEC, ADDR -> grants in order 0,1,2,3,0. Strobe patterns are 0111, 0101, 0100, 1011 respectively, with one IDLE cycle between each.
3. hold_i=1 with req_i=0010 -> no grant and busy_o=0 while hold is high. Drop hold -> SETUP on the next cycle. Raising hold_i during EXEC does not stall; ack arrives on schedule.
4. Grant requester 2 (op DEC), then drop req_i[2] during EXEC -> ack_o=0100 still pulses, strobes stay 0100 until DONE.
5. Assert rst_n=0 mid-EXEC -> strobes become 1111 in the same cycle without waiting for a clock edge, ack never pulses. After release, the re-request completes normally and the rr pointer starts from 0.
6. req_i=1000, then req_i=1001 right after ack -> requester 0 is granted before requester 3 is regranted, because the pointer wrapped to 0 after serving requester 3.
